// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: word RAM plus an MMIO page (GPIO, cycle counter, countdown timer).
// Reads are combinational (zero latency); all state changes on the rising edge; no backpressure.
module dmem_mmio #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    localparam logic [15:0] OFF_GPIO_OUT = 16'h0000;
    localparam logic [15:0] OFF_GPIO_IN  = 16'h0004;
    localparam logic [15:0] OFF_CYCLE    = 16'h0008;
    localparam logic [15:0] OFF_TIMER    = 16'h000C;
    localparam logic [15:0] OFF_TSTAT    = 16'h0010;

    logic [31:0]       r_ram [DEPTH];
    logic [GPIO_W-1:0] r_gpio_out;
    logic [GPIO_W-1:0] r_sync1;
    logic [GPIO_W-1:0] r_sync2;
    logic [31:0]       r_cycle;
    logic [31:0]       r_timer;
    logic              r_expired;

    logic              w_is_ram;
    logic              w_is_mmio;
    logic [15:0]       w_off;
    logic [AW-1:0]     w_idx;
    logic              w_wr_mmio;
    logic              w_ld_timer;
    logic              w_clr_stat;
    logic              w_expire;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_is_ram   = (DataAdr[31:2] < DEPTH_W);
    assign w_is_mmio  = (DataAdr[31:16] == MMIO_BASE[31:16]);
    assign w_off      = DataAdr[15:0];
    assign w_idx      = DataAdr[AW+1:2];
    assign w_wr_mmio  = MemWrite && w_is_mmio;
    assign w_ld_timer = w_wr_mmio && (w_off == OFF_TIMER);
    assign w_clr_stat = w_wr_mmio && (w_off == OFF_TSTAT);
    // A load at the expiry edge suppresses the expiry; expiry beats a status clear.
    assign w_expire   = !w_ld_timer && (r_timer == 32'd1);
    assign w_unused   = ^DataAdr[1:0];

    always_ff @(posedge clk) begin
        if (!rst && MemWrite && w_is_ram) begin
            r_ram[w_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_cycle    <= 32'd0;
            r_timer    <= 32'd0;
            r_expired  <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (w_wr_mmio && (w_off == OFF_GPIO_OUT)) begin
                r_gpio_out <= WriteData[GPIO_W-1:0];
            end
            if (w_ld_timer) begin
                r_timer <= WriteData;
            end else if (r_timer != 32'd0) begin
                r_timer <= r_timer - 32'd1;
            end
            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (w_clr_stat) begin
                r_expired <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_is_ram) begin
            w_rdata = r_ram[w_idx];
        end else if (w_is_mmio) begin
            case (w_off)
                OFF_GPIO_OUT: w_rdata = 32'(r_gpio_out);
                OFF_GPIO_IN:  w_rdata = 32'(r_sync2);
                OFF_CYCLE:    w_rdata = r_cycle;
                OFF_TIMER:    w_rdata = r_timer;
                OFF_TSTAT:    w_rdata = {31'd0, r_expired};
                default:      w_rdata = 32'd0;
            endcase
        end
    end

    assign ReadData  = w_rdata;
    assign gpio_out  = r_gpio_out;
    assign timer_irq = r_expired;
endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus queues expected values per cycle, a negedge monitor checks them.
module tb_dmem_mmio;
    localparam logic [31:0] B = 32'hFFFF_0000;
    localparam int K_RD = 0, K_GPIO = 1, K_IRQ = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic [7:0]  gpio_in = 8'd0;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    dmem_mmio #(.DEPTH(64), .MMIO_BASE(B), .GPIO_W(8)) dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    cyc_n = 0;
    int    total = 0;
    int    bad = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // One bus cycle: inputs change just after the edge and are sampled at the next one.
    task automatic drv(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = r;
        MemWrite = we;
        DataAdr = a;
        WriteData = d;
    endtask

    task automatic expv(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = cyc_n;
        e.kind = kind;
        e.val = v;
        q.push_back(e);
        qn.push_back(nm);
    endtask

    always @(negedge clk) begin
        logic [31:0] act;
        exp_t e;
        string nm;
        while (q.size() > 0 && q[0].cyc <= cyc_n) begin
            e = q.pop_front();
            nm = qn.pop_front();
            case (e.kind)
                K_GPIO:  act = {24'd0, gpio_out};
                K_IRQ:   act = {31'd0, timer_irq};
                default: act = ReadData;
            endcase
            total = total + 1;
            if (e.cyc != cyc_n || act !== e.val) begin
                bad = bad + 1;
                $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, e.val, cyc_n);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, including a write that must be discarded
        drv(1, 0, 0, 0);
        drv(1, 1, B + 32'h0, 32'hFF);
        drv(0, 0, B + 32'h8, 0);  expv(K_RD, 0, "cycle0"); expv(K_GPIO, 0, "rst_gpio"); expv(K_IRQ, 0, "rst_irq");
        drv(0, 0, B + 32'h8, 0);  expv(K_RD, 1, "cycle1");
        drv(0, 0, B + 32'h8, 0);  expv(K_RD, 2, "cycle2");
        drv(0, 0, B + 32'h8, 0);  expv(K_RD, 3, "cycle3");
        drv(0, 0, B + 32'h8, 0);  expv(K_RD, 4, "cycle4");
        drv(0, 0, B + 32'hC, 0);  expv(K_RD, 0, "rst_timer");
        drv(0, 0, B + 32'h10, 0); expv(K_RD, 0, "rst_tstat");

        // RAM
        drv(0, 1, 32'h10, 32'hDEAD_BEEF);
        drv(0, 0, 32'h10, 0);  expv(K_RD, 32'hDEAD_BEEF, "ram_rd10");
        drv(0, 0, 32'h13, 0);  expv(K_RD, 32'hDEAD_BEEF, "ram_rd13");
        drv(0, 0, 32'h100, 0); expv(K_RD, 0, "unmapped_rd");
        drv(0, 1, 32'h100, 32'h1234_5678);
        drv(0, 0, 32'h100, 0); expv(K_RD, 0, "unmapped_wr");
        drv(0, 1, 32'hFC, 32'h5555_AAAA);
        drv(0, 0, 32'hFC, 0);  expv(K_RD, 32'h5555_AAAA, "ram_top");
        drv(0, 1, 32'h10, 32'h1111_2222); expv(K_RD, 32'hDEAD_BEEF, "ram_same_cyc_old");
        drv(0, 0, 32'h10, 0);  expv(K_RD, 32'h1111_2222, "ram_new");

        // GPIO out
        drv(0, 1, B + 32'h0, 32'h1A5); expv(K_GPIO, 0, "gpio_out_before");
        drv(0, 0, B + 32'h0, 0);       expv(K_RD, 32'hA5, "gpio_rd"); expv(K_GPIO, 32'hA5, "gpio_out");
        drv(0, 0, B + 32'h14, 0);      expv(K_RD, 0, "mmio_other_off");

        // GPIO in through the synchronizer
        drv(0, 0, B + 32'h4, 0); gpio_in = 8'h3C; expv(K_RD, 0, "gpio_in_t0");
        drv(0, 0, B + 32'h4, 0); expv(K_RD, 0, "gpio_in_t1");
        drv(0, 0, B + 32'h4, 0); expv(K_RD, 32'h3C, "gpio_in_t2");
        drv(0, 1, B + 32'h4, 32'hFF);
        drv(0, 0, B + 32'h4, 0); expv(K_RD, 32'h3C, "gpio_in_ro");

        // Cycle counter wrap
        drv(0, 0, B + 32'h8, 0);
        force dut.r_cycle = 32'hFFFF_FFFF;
        expv(K_RD, 32'hFFFF_FFFF, "cycle_max");
        #6;
        release dut.r_cycle;
        drv(0, 0, B + 32'h8, 0); expv(K_RD, 0, "cycle_wrap");

        // Timer countdown and sticky flag
        drv(0, 1, B + 32'hC, 3);
        drv(0, 0, B + 32'hC, 0);  expv(K_RD, 3, "timer3");
        drv(0, 0, B + 32'hC, 0);  expv(K_RD, 2, "timer2");
        drv(0, 0, B + 32'hC, 0);  expv(K_RD, 1, "timer1"); expv(K_IRQ, 0, "irq_pre");
        drv(0, 0, B + 32'hC, 0);  expv(K_RD, 0, "timer0"); expv(K_IRQ, 1, "irq_rise");
        drv(0, 0, B + 32'h10, 0); expv(K_RD, 1, "tstat_set");
        drv(0, 0, B + 32'hC, 0);  expv(K_RD, 0, "timer_stays0"); expv(K_IRQ, 1, "irq_sticky");
        drv(0, 1, B + 32'h10, 32'hABC);
        drv(0, 0, B + 32'h10, 0); expv(K_RD, 0, "tstat_clr"); expv(K_IRQ, 0, "irq_clr");

        // Load 0 stops without expiry
        drv(0, 1, B + 32'hC, 5);
        drv(0, 1, B + 32'hC, 0);  expv(K_RD, 5, "timer5");
        drv(0, 0, B + 32'hC, 0);  expv(K_RD, 0, "timer_stop");
        drv(0, 0, B + 32'h10, 0); expv(K_RD, 0, "stop_no_exp"); expv(K_IRQ, 0, "stop_no_irq");

        // Race: clear at the expiry edge
        drv(0, 1, B + 32'hC, 1);
        drv(0, 1, B + 32'h10, 0); expv(K_RD, 0, "race1_tstat_before");
        drv(0, 0, B + 32'h10, 0); expv(K_RD, 1, "race1_set_wins"); expv(K_IRQ, 1, "race1_irq");
        drv(0, 1, B + 32'h10, 0);
        drv(0, 0, B + 32'h10, 0); expv(K_RD, 0, "race1_cleared");

        // Race: reload at the expiry edge
        drv(0, 1, B + 32'hC, 1);
        drv(0, 1, B + 32'hC, 5);
        drv(0, 0, B + 32'hC, 0);  expv(K_RD, 5, "race2_reload"); expv(K_IRQ, 0, "race2_irq");
        drv(0, 0, B + 32'h10, 0); expv(K_RD, 0, "race2_no_exp");
        drv(0, 0, B + 32'hC, 0);  expv(K_RD, 3, "race2_running");

        // Reset mid-countdown
        drv(0, 1, B + 32'h0, 32'h77);
        drv(0, 1, B + 32'hC, 10);  expv(K_GPIO, 32'h77, "pre_rst_gpio");
        drv(0, 0, B + 32'hC, 0);   expv(K_RD, 10, "mid10");
        drv(0, 0, B + 32'hC, 0);   expv(K_RD, 9, "mid9");
        drv(0, 0, B + 32'hC, 0);   expv(K_RD, 8, "mid8");
        drv(0, 0, B + 32'hC, 0);   expv(K_RD, 7, "mid7");
        drv(1, 1, B + 32'h0, 32'h55);
        drv(0, 0, B + 32'h8, 0);   expv(K_RD, 0, "post_rst_cycle"); expv(K_GPIO, 0, "post_rst_gpio");
        drv(0, 0, B + 32'hC, 0);   expv(K_RD, 0, "post_rst_timer"); expv(K_IRQ, 0, "post_rst_irq");
        drv(0, 0, B + 32'h10, 0);  expv(K_RD, 0, "post_rst_tstat");
        drv(0, 0, 32'hFC, 0);      expv(K_RD, 32'h5555_AAAA, "post_rst_ram");
        drv(0, 0, 32'h10, 0);      expv(K_RD, 32'h1111_2222, "post_rst_ram2");

        drv(0, 0, 0, 0);
        drv(0, 0, 0, 0);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
